// File: rtl/dual_prime_mv.sv
// ---------------------------------------------------------------------------
// dual_prime_mv
//
// Derives the dual-prime motion vectors for one macroblock from a base field
// vector and a dmvector. A field picture yields one vector; a frame picture
// yields two (index 0 then index 1). Each vector is offered on a valid/ack
// handshake, and a one-cycle done pulse follows the last acknowledged vector.
//
// Parameters
//   MV_W            signed motion-vector component width
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             synchronous reset, active low
//   inReady         start strobe, operands sampled when high and not busy
//   mv_x, mv_y      base field motion vector (signed, MV_W)
//   dmv_x, dmv_y    dmvector, signed 2-bit, restricted to -1/0/+1
//   pic_struct      01 top field, 10 bottom field, 11 frame, 00 reserved
//   top_field_first picture coding extension flag
//   out_ack         consumer accepts the current vector
//   busy            high from operand capture until the done pulse
//   out_valid       derived vector available
//   vec_x, vec_y    derived vector (signed, MV_W)
//   vec_idx         index of the derived vector (0 or 1)
//   done            one-cycle pulse after the last vector is accepted
// ---------------------------------------------------------------------------
module dual_prime_mv #(
    parameter int MV_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inReady,
    input  logic signed [MV_W-1:0] mv_x,
    input  logic signed [MV_W-1:0] mv_y,
    input  logic signed [1:0]      dmv_x,
    input  logic signed [1:0]      dmv_y,
    input  logic [1:0]             pic_struct,
    input  logic                   top_field_first,
    input  logic                   out_ack,
    output logic                   busy,
    output logic                   out_valid,
    output logic signed [MV_W-1:0] vec_x,
    output logic signed [MV_W-1:0] vec_y,
    output logic [1:0]             vec_idx,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC0 = 3'd1,
        OUT0  = 3'd2,
        CALC1 = 3'd3,
        OUT1  = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [1:0] PIC_RSVD   = 2'b00;
    localparam logic [1:0] PIC_TOP    = 2'b01;
    localparam logic [1:0] PIC_FRAME  = 2'b11;

    localparam logic signed [1:0] E_NEG = 2'sb11;  // -1
    localparam logic signed [1:0] E_POS = 2'sb01;  // +1
    localparam logic signed [1:0] E_NONE = 2'sb00;

    state_t                 state_q;
    logic signed [MV_W-1:0] mv_x_q, mv_y_q;
    logic signed [1:0]      dmv_x_q, dmv_y_q;
    logic [1:0]             pic_q;
    logic                   tff_q;
    logic                   busy_q, out_valid_q, done_q;
    logic signed [MV_W-1:0] vec_x_q, vec_y_q;
    logic [1:0]             vec_idx_q;

    logic signed [MV_W-1:0] vec_x_d, vec_y_d;

    // One component: ((mv*m + (mv>0)) >>> 1) + dmv + e, with m either 1 or 3.
    // Intermediates carry three guard bits so mv*3 cannot overflow; the
    // result wraps to MV_W bits.
    function automatic logic signed [MV_W-1:0] derive(
        input logic signed [MV_W-1:0] mv,
        input logic                   triple,
        input logic signed [1:0]      dmv,
        input logic signed [1:0]      e
    );
        logic signed [MV_W+2:0] ext;
        logic signed [MV_W+2:0] acc;
        logic                   pos;
        ext = {{3{mv[MV_W-1]}}, mv};
        pos = !mv[MV_W-1] && (|mv);
        acc = triple ? ((ext <<< 1) + ext) : ext;
        acc = acc + {{(MV_W+2){1'b0}}, pos};
        acc = acc >>> 1;
        acc = acc + {{(MV_W+1){dmv[1]}}, dmv} + {{(MV_W+1){e[1]}}, e};
        return acc[MV_W-1:0];
    endfunction

    // Vector selection: CALC1 only occurs for frames and produces vector 1;
    // otherwise vector 0 of a frame or the single field vector.
    always_comb begin
        logic                is_frame;
        logic                triple;
        logic signed [1:0]   e;
        is_frame = (pic_q == PIC_FRAME);
        if (state_q == CALC1) begin
            triple = tff_q;
            e      = E_POS;
        end else if (is_frame) begin
            triple = !tff_q;
            e      = E_NEG;
        end else begin
            triple = 1'b0;
            e      = (pic_q == PIC_TOP) ? E_NEG : E_POS;
        end
        vec_x_d = derive(mv_x_q, triple, dmv_x_q, E_NONE);
        vec_y_d = derive(mv_y_q, triple, dmv_y_q, e);
    end

    // NOTE: state is updated with non-blocking assignments and the reset is
    // checked inside the clocked block, so reset only acts on a rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            vec_x_q     <= '0;
            vec_y_q     <= '0;
            vec_idx_q   <= 2'd0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
            dmv_x_q     <= '0;
            dmv_y_q     <= '0;
            pic_q       <= '0;
            tff_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (inReady) begin
                        mv_x_q  <= mv_x;
                        mv_y_q  <= mv_y;
                        dmv_x_q <= dmv_x;
                        dmv_y_q <= dmv_y;
                        pic_q   <= pic_struct;
                        tff_q   <= top_field_first;
                        busy_q  <= 1'b1;
                        state_q <= CALC0;
                    end
                end
                CALC0: begin
                    if (pic_q == PIC_RSVD) begin
                        // Reserved structure: nothing to emit, finish at once.
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        vec_x_q     <= vec_x_d;
                        vec_y_q     <= vec_y_d;
                        vec_idx_q   <= 2'd0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT0;
                    end
                end
                OUT0: begin
                    if (out_ack) begin
                        out_valid_q <= 1'b0;
                        if (pic_q == PIC_FRAME) begin
                            state_q <= CALC1;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                CALC1: begin
                    vec_x_q     <= vec_x_d;
                    vec_y_q     <= vec_y_d;
                    vec_idx_q   <= 2'd1;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT1;
                end
                OUT1: begin
                    if (out_ack) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign vec_x     = vec_x_q;
    assign vec_y     = vec_y_q;
    assign vec_idx   = vec_idx_q;
    assign done      = done_q;

endmodule
